// File: rtl/mipi_lane_isp_arbiter.sv
// mipi_lane_isp_arbiter
// Shares the single ISP raw input between the two CSI-2 lane packet decoders.
// Packet-granular round-robin: a lane keeps the grant from its first beat to
// its last beat. A starve watchdog frees the ISP if the granted lane goes
// quiet mid-packet. Per-lane completed-packet counters feed Wishbone status.
module mipi_lane_isp_arbiter #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024,
    parameter int CNTW    = 16
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            s0_valid,
    output logic            s0_ready,
    input  logic [DW-1:0]   s0_data,
    input  logic            s0_last,
    input  logic            s1_valid,
    output logic            s1_ready,
    input  logic [DW-1:0]   s1_data,
    input  logic            s1_last,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DW-1:0]   m_data,
    output logic            m_last,
    output logic            m_lane,
    output logic            m_abort,
    output logic            busy,
    output logic [CNTW-1:0] pkt_cnt0,
    output logic [CNTW-1:0] pkt_cnt1
);

    // Watchdog counter must be able to hold TIMEOUT-1; width stays >= 1 even
    // when the watchdog is disabled.
    localparam int              WDW     = $clog2(TIMEOUT + 2);
    localparam bit              WD_EN   = (TIMEOUT > 0);
    localparam logic [WDW-1:0]  WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t               state;
    logic                 last_grant;
    logic [WDW-1:0]       wd_cnt;

    logic [1:0]           lane_valid;
    logic [1:0]           lane_last;
    logic [1:0]           lane_ready;
    logic [1:0]           lane_done;
    logic [1:0][DW-1:0]   lane_data;
    logic [1:0][CNTW-1:0] pkt_cnt;

    logic                 granted;
    logic                 sel;
    logic                 xfer;
    logic                 pkt_done;
    logic                 starve;
    logic                 wd_fire;

    assign lane_valid = {s1_valid, s0_valid};
    assign lane_last  = {s1_last, s0_last};
    assign lane_data  = {s1_data, s0_data};

    assign granted    = (state != IDLE);
    assign sel        = (state == GNT1);

    assign s0_ready   = lane_ready[0];
    assign s1_ready   = lane_ready[1];
    assign pkt_cnt0   = pkt_cnt[0];
    assign pkt_cnt1   = pkt_cnt[1];

    // Zero-latency output mux from the granted lane; everything is quiet in IDLE.
    always_comb begin
        m_valid         = granted & lane_valid[sel];
        m_data          = granted ? lane_data[sel] : '0;
        m_last          = granted & lane_last[sel];
        m_lane          = sel;
        lane_ready      = '0;
        lane_ready[sel] = granted & m_ready;
    end

    // Transfer / end-of-packet / watchdog decode. A lane that is valid but
    // back-pressured is not starving, so only !valid cycles advance the count.
    always_comb begin
        xfer           = m_valid & m_ready;
        pkt_done       = xfer & m_last;
        starve         = granted & ~lane_valid[sel];
        wd_fire        = WD_EN && starve && (wd_cnt == WD_LAST);
        m_abort        = wd_fire;
        lane_done      = '0;
        lane_done[sel] = pkt_done;
    end

    // Arbitration FSM: grant on request, hold to last beat or watchdog release.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wd_cnt     <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (enable && (|lane_valid)) begin
                        busy <= 1'b1;
                        if (&lane_valid)
                            state <= last_grant ? GNT0 : GNT1;
                        else
                            state <= lane_valid[0] ? GNT0 : GNT1;
                    end
                end
                GNT0, GNT1: begin
                    if (pkt_done || wd_fire) begin
                        state      <= IDLE;
                        last_grant <= sel;
                        busy       <= 1'b0;
                        wd_cnt     <= '0;
                    end else if (starve && WD_EN) begin
                        wd_cnt <= wd_cnt + WDW'(1);
                    end else begin
                        wd_cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    wd_cnt <= '0;
                end
            endcase
        end
    end

    // Completed-packet counters; wrap naturally, truncated packets never count.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++)
                if (lane_done[i])
                    pkt_cnt[i] <= pkt_cnt[i] + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_mipi_lane_isp_arbiter.sv
// Directed bench for mipi_lane_isp_arbiter. Inputs change on the falling
// edge; outputs are sampled 1ns later so the combinational mux has settled
// and the next rising edge commits what was observed.
module tb_mipi_lane_isp_arbiter;

    localparam int DW      = 32;
    localparam int TIMEOUT = 1024;
    localparam int CNTW    = 4;   // narrow so the wrap case stays short

    logic            pclk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b1;
    logic            s0_valid = 1'b0, s0_last = 1'b0;
    logic            s1_valid = 1'b0, s1_last = 1'b0;
    logic [DW-1:0]   s0_data = '0, s1_data = '0;
    logic            m_ready = 1'b1;
    logic            s0_ready, s1_ready, m_valid, m_last, m_lane, m_abort, busy;
    logic [DW-1:0]   m_data;
    logic [CNTW-1:0] pkt_cnt0, pkt_cnt1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 pclk = ~pclk;

    mipi_lane_isp_arbiter #(.DW(DW), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
        .pclk(pclk), .rst_n(rst_n), .enable(enable),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data), .s0_last(s0_last),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data), .s1_last(s1_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .m_lane(m_lane), .m_abort(m_abort), .busy(busy),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Back-to-back single-beat lane 1 packets until n transfers are seen.
    task automatic run_l1(input int n);
        int got;
        got = 0;
        for (int c = 0; c < 4 * n + 4 && got < n; c++) begin
            @(negedge pclk);
            s1_valid = 1'b1; s1_last = 1'b1; s1_data = 32'h5A;
            #1;
            if (s1_ready) got++;
        end
        @(negedge pclk);
        s1_valid = 1'b0; s1_last = 1'b0;
        #1;
        chk("l1_run", got, n);
    endtask

    initial begin
        int p0, b0, p1, b1, pk, bt, ab, ab_at, rdy, bad;
        bit gap;

        // ---- reset values
        @(negedge pclk); #1;
        chk("rst_outs", {s0_ready, s1_ready, m_valid, m_last, m_lane, m_abort, busy}, 0);
        chk("rst_data", m_data, 0);
        chk("rst_cnt", {pkt_cnt0, pkt_cnt1}, 0);
        @(negedge pclk); rst_n = 1'b1;

        // ---- lane 0 only, 4 beats A0..A3
        @(negedge pclk);
        s0_valid = 1'b1; s0_data = 32'hA0; #1;
        chk("l0_idle", {busy, m_valid, s0_ready}, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            s0_data = 32'hA0 + 32'(i); s0_last = (i == 3); #1;
            chk("l0_vld", {busy, m_valid, s0_ready, m_lane}, 4'b1110);
            chk("l0_data", m_data, 32'hA0 + i);
            chk("l0_last", m_last, (i == 3));
        end
        @(negedge pclk);
        s0_valid = 1'b0; s0_last = 1'b0; #1;
        chk("l0_busy_done", busy, 0);
        chk("l0_cnt", pkt_cnt0, 1);

        // ---- both lanes saturated, 3-beat packets, round-robin from reset
        @(negedge pclk); rst_n = 1'b0;
        @(negedge pclk); rst_n = 1'b1;
        p0 = 0; b0 = 0; p1 = 0; b1 = 0; pk = 0; bt = 0; gap = 0;
        for (int c = 0; c < 40 && pk < 4; c++) begin
            @(negedge pclk);
            s0_valid = 1'b1; s0_data = 32'(p0 * 256 + b0); s0_last = (b0 == 2);
            s1_valid = 1'b1; s1_data = 32'h0100_0000 | 32'(p1 * 256 + b1); s1_last = (b1 == 2);
            #1;
            chk("rr_excl", s0_ready & s1_ready, 0);
            if (gap) begin
                chk("rr_gap", m_valid, 0);
                gap = 0;
            end else if (m_valid && m_ready) begin
                chk("rr_lane", m_lane, pk % 2);
                chk("rr_data", m_data, ((pk % 2) ? 32'h0100_0000 : 32'h0) | 32'((pk / 2) * 256 + bt));
                chk("rr_last", m_last, (bt == 2));
                if (bt == 2) begin bt = 0; pk++; gap = 1; end
                else bt++;
            end
            if (s0_ready) begin if (b0 == 2) begin b0 = 0; p0++; end else b0++; end
            if (s1_ready) begin if (b1 == 2) begin b1 = 0; p1++; end else b1++; end
        end
        chk("rr_pkts", pk, 4);
        @(negedge pclk);
        s0_valid = 1'b0; s1_valid = 1'b0; s0_last = 1'b0; s1_last = 1'b0; #1;
        chk("rr_cnt0", pkt_cnt0, 2);
        chk("rr_cnt1", pkt_cnt1, 2);

        // ---- lane 1 granted, ISP stalls 2000 cycles: no watchdog
        @(negedge pclk);
        m_ready = 1'b0; s1_valid = 1'b1; s1_data = 32'hB0; s1_last = 1'b0; #1;
        chk("stall_idle", busy, 0);
        ab = 0; rdy = 0; bad = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge pclk); #1;
            if (m_abort) ab++;
            if (s1_ready) rdy++;
            if (!busy || !m_lane || !m_valid) bad++;
        end
        chk("stall_abort", ab, 0);
        chk("stall_ready", rdy, 0);
        chk("stall_hold", bad, 0);
        @(negedge pclk); m_ready = 1'b1; #1;
        chk("stall_resume", {s1_ready, m_data}, {1'b1, 32'hB0});
        @(negedge pclk); s1_data = 32'hB1; s1_last = 1'b1; #1;
        chk("stall_last", {m_last, m_data}, {1'b1, 32'hB1});
        @(negedge pclk); s1_valid = 1'b0; s1_last = 1'b0; #1;
        chk("stall_done", busy, 0);
        chk("stall_cnt1", pkt_cnt1, 3);

        // ---- lane 0 starves after 2 beats; watchdog frees it for lane 1
        @(negedge pclk); s0_valid = 1'b1; s0_data = 32'hC0; s0_last = 1'b0; #1;
        @(negedge pclk); #1;
        chk("wd_b0", m_data, 32'hC0);
        @(negedge pclk); s0_data = 32'hC1; #1;
        chk("wd_b1", m_data, 32'hC1);
        ab = 0; ab_at = 0;
        for (int k = 1; k <= 1026; k++) begin
            @(negedge pclk);
            if (k == 1) begin
                s0_valid = 1'b0; s1_valid = 1'b1; s1_data = 32'hD0; s1_last = 1'b1;
            end
            #1;
            if (m_abort) begin ab++; if (ab_at == 0) ab_at = k; end
            if (k == 1026) begin
                chk("wd_next_lane", {m_valid, m_lane}, 2'b11);
                chk("wd_next_data", m_data, 32'hD0);
            end
        end
        chk("wd_abort_cnt", ab, 1);
        chk("wd_abort_at", ab_at, 1024);
        @(negedge pclk); s1_valid = 1'b0; s1_last = 1'b0; #1;
        chk("wd_cnt0", pkt_cnt0, 2);
        chk("wd_cnt1", pkt_cnt1, 4);

        // ---- enable dropped during beat 2 of a 5-beat lane 0 packet
        @(negedge pclk);
        s0_valid = 1'b1; s0_data = 32'hE0; s0_last = 1'b0;
        s1_valid = 1'b1; s1_data = 32'hF0; s1_last = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            s0_data = 32'hE0 + 32'(i); s0_last = (i == 4);
            if (i == 1) enable = 1'b0;
            #1;
            chk("en_lane", {m_valid, m_lane}, 2'b10);
            chk("en_data", m_data, 32'hE0 + i);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge pclk);
            s0_valid = 1'b0; s0_last = 1'b0; #1;
            chk("en_hold", {busy, m_valid}, 0);
        end
        @(negedge pclk); enable = 1'b1; #1;
        chk("en_reidle", busy, 0);
        @(negedge pclk); #1;
        chk("en_l1_grant", {m_valid, m_lane}, 2'b11);
        chk("en_l1_data", m_data, 32'hF0);
        @(negedge pclk); s1_valid = 1'b0; s1_last = 1'b0; #1;
        chk("en_cnt0", pkt_cnt0, 3);
        chk("en_cnt1", pkt_cnt1, 5);

        // ---- counter wrap: 5 + 10 = 15 (all ones), one more wraps to 0
        run_l1(10);
        chk("wrap_max", pkt_cnt1, 15);
        run_l1(1);
        chk("wrap_zero", pkt_cnt1, 0);

        // ---- make lane 0 the last grant, then reset mid-packet
        @(negedge pclk); s0_valid = 1'b1; s0_data = 32'h66; s0_last = 1'b1; #1;
        @(negedge pclk); #1;
        chk("pre_rst_single", {m_valid, m_lane, m_last}, 3'b101);
        @(negedge pclk); s0_data = 32'h77; s0_last = 1'b0; #1;
        @(negedge pclk); #1;
        chk("pre_rst_beat", {m_valid, m_lane, busy}, 3'b101);
        @(negedge pclk); rst_n = 1'b0; s1_valid = 1'b1; s1_data = 32'h88; #1;
        chk("mid_rst_outs", {s0_ready, s1_ready, m_valid, m_last, m_lane, m_abort, busy}, 0);
        chk("mid_rst_data", m_data, 0);
        chk("mid_rst_cnt", {pkt_cnt0, pkt_cnt1}, 0);
        @(negedge pclk); rst_n = 1'b1; #1;
        chk("post_rst_idle", busy, 0);
        @(negedge pclk); #1;
        chk("post_rst_tie", {m_valid, m_lane}, 2'b10);
        chk("post_rst_data", m_data, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
